pipe_hazard_regs: RTL

- IF/ID and ID/EX pipeline registers of the 5-stage MIPS datapath.
- This is the consumer end of the hazard-unit interface. It acts on IF_ID_write (hold), controlSel (bubble) and IF_flush (squash).
- It returns ID_EX_memRead and ID_EX_Rt to the hazard unit.
- It also keeps saturating stall, bubble and flush event counters for performance debug.

---
 rtl/pipe_hazard_regs_pkg.sv | 26 ++
 rtl/pipe_hazard_regs_sat_counter.sv | 30 +++
 rtl/pipe_hazard_regs.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_regs_pkg.sv
// Shared pipeline definitions for the IF/ID and ID/EX register slice.
// Provides the NOP encoding, the control-bundle layout and its width,
// the memRead bit position and the all-zero control word used for bubbles.
package pipe_hazard_regs_pkg;

    localparam int CTRL_BUNDLE_W = 9;
    localparam int MEMREAD_IDX   = 3;

    // The control bundle as it sits in ID/EX; the field order fixes the bit indices:
    // [0] regDst [1] aluSrc [2] memToReg [3] memRead [4] memWrite
    // [5] regWrite [7:6] aluOp [8] branch
    typedef struct packed {
        logic       branch;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
    } ctrl_t;

    localparam logic [31:0]              NOP_INST  = 32'h0000_0000;
    localparam logic [CTRL_BUNDLE_W-1:0] CTRL_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_regs_sat_counter.sv
// Saturating event counter: counts up by one on each clock with inc=1 and
// stops at all-ones (no wrap).
// Ports: clk (rising edge), rst (async active-low), inc (count enable),
//        count (current value).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_regs.sv
// IF/ID and ID/EX pipeline registers of the 5-stage MIPS datapath, acting on
// the hazard-unit controls (IF_ID_write hold, controlSel bubble, IF_flush
// squash) and returning ID_EX_memRead / ID_EX_Rt to the hazard unit.
// Ports:
//   clk, rst (async active-low)
//   IF_ID_write, controlSel, IF_flush      hazard controls
//   pcPlus4_in, inst_in                    IF stage inputs
//   ctrl_in, readData1/2_in, signExt_in,
//   Rs_in, Rt_in, Rd_in                    ID stage inputs
//   IF_ID_*                                IF/ID register contents
//   ID_EX_*                                ID/EX register contents
//   stallCount, bubbleCount, flushCount    saturating event counters
module pipe_hazard_regs
    import pipe_hazard_regs_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CTRL_W      = CTRL_BUNDLE_W,
    parameter int MEMREAD_BIT = MEMREAD_IDX,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IF_ID_write,
    input  logic              controlSel,
    input  logic              IF_flush,
    input  logic [WIDTH-1:0]  pcPlus4_in,
    input  logic [WIDTH-1:0]  inst_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [WIDTH-1:0]  readData1_in,
    input  logic [WIDTH-1:0]  readData2_in,
    input  logic [WIDTH-1:0]  signExt_in,
    input  logic [4:0]        Rs_in,
    input  logic [4:0]        Rt_in,
    input  logic [4:0]        Rd_in,
    output logic [WIDTH-1:0]  IF_ID_pcPlus4,
    output logic [WIDTH-1:0]  IF_ID_inst,
    output logic              IF_ID_valid,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic [WIDTH-1:0]  ID_EX_readData1,
    output logic [WIDTH-1:0]  ID_EX_readData2,
    output logic [WIDTH-1:0]  ID_EX_signExt,
    output logic [4:0]        ID_EX_Rs,
    output logic [4:0]        ID_EX_Rt,
    output logic [4:0]        ID_EX_Rd,
    output logic              ID_EX_memRead,
    output logic              ID_EX_valid,
    output logic [CNT_W-1:0]  stallCount,
    output logic [CNT_W-1:0]  bubbleCount,
    output logic [CNT_W-1:0]  flushCount
);

    logic [WIDTH-1:0]  if_pc_q, if_pc_d;
    logic [WIDTH-1:0]  if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [WIDTH-1:0]  ex_rd1_q, ex_rd1_d;
    logic [WIDTH-1:0]  ex_rd2_q, ex_rd2_d;
    logic [WIDTH-1:0]  ex_se_q, ex_se_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic              ex_valid_q, ex_valid_d;

    logic stall_ev, bubble_ev, flush_ev;

    // IF/ID: a stall outranks a flush, because the branch sitting in ID is
    // itself stalled and its taken/not-taken decision is not yet trustworthy.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        flush_ev   = 1'b0;
        if (IF_ID_write) begin
            if_pc_d = pcPlus4_in;
            if (IF_flush) begin
                if_inst_d  = WIDTH'(NOP_INST);
                if_valid_d = 1'b0;
                flush_ev   = 1'b1;
            end else begin
                if_inst_d  = inst_in;
                if_valid_d = 1'b1;
            end
        end
    end

    assign stall_ev = !IF_ID_write;

    // A squashed IF/ID slot must not reach EX with live control either, so an
    // invalid IF/ID forces a bubble just like controlSel=0.
    assign bubble_ev = !controlSel || !if_valid_q;

    always_comb begin
        ex_rd1_d   = readData1_in;
        ex_rd2_d   = readData2_in;
        ex_se_d    = signExt_in;
        ex_rs_d    = Rs_in;
        ex_rt_d    = Rt_in;
        ex_rd_d    = Rd_in;
        ex_ctrl_d  = ctrl_in;
        ex_valid_d = 1'b1;
        if (bubble_ev) begin
            ex_ctrl_d  = CTRL_W'(CTRL_ZERO);
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_se_q    <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_se_q    <= ex_se_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign IF_ID_pcPlus4   = if_pc_q;
    assign IF_ID_inst      = if_inst_q;
    assign IF_ID_valid     = if_valid_q;
    assign ID_EX_ctrl      = ex_ctrl_q;
    assign ID_EX_readData1 = ex_rd1_q;
    assign ID_EX_readData2 = ex_rd2_q;
    assign ID_EX_signExt   = ex_se_q;
    assign ID_EX_Rs        = ex_rs_q;
    assign ID_EX_Rt        = ex_rt_q;
    assign ID_EX_Rd        = ex_rd_q;
    assign ID_EX_valid     = ex_valid_q;
    // Taken from the registered ctrl so a bubble clears it, which ends a
    // load-use stall after exactly one cycle.
    assign ID_EX_memRead   = ex_ctrl_q[MEMREAD_BIT];

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc(stall_ev), .count(stallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk(clk), .rst(rst), .inc(bubble_ev), .count(bubbleCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .inc(flush_ev), .count(flushCount)
    );

endmodule
